// File: rtl/arp_pkg.sv
// Shared ARP protocol constants and TX state type for the ARP TX/RX blocks.
// Optional build macro ARP_PAD_EN adds the PAD state (zero padding to 46 bytes).
package arp_pkg;

  localparam logic [15:0] HTYPE     = 16'h0001;
  localparam logic [15:0] PTYPE     = 16'h0800;
  localparam logic [7:0]  HLEN      = 8'h06;
  localparam logic [7:0]  PLEN      = 8'h04;
  localparam logic [15:0] OPER_RQ   = 16'h0001;
  localparam logic [15:0] OPER_RESP = 16'h0002;
  localparam logic [47:0] MAC_Z     = 48'h0;

  localparam int ARP_LEN     = 28;
  localparam int ARP_PAD_LEN = 46;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SHA,
    ST_SPA,
    ST_THA,
    ST_TPA,
    ST_DONE
`ifdef ARP_PAD_EN
    , ST_PAD
`endif
  } arp_tx_state_e;

  // Field the given payload byte index falls into.
  function automatic arp_tx_state_e txStateOf(input logic [5:0] idx);
    if (idx < 6'd8)       return ST_HDR;
    else if (idx < 6'd14) return ST_SHA;
    else if (idx < 6'd18) return ST_SPA;
    else if (idx < 6'd24) return ST_THA;
    else if (idx < 6'd28) return ST_TPA;
`ifdef ARP_PAD_EN
    else                  return ST_PAD;
`else
    else                  return ST_TPA;
`endif
  endfunction

endpackage

// File: rtl/arp_data_tx.sv
// ARP payload serialiser: latches addresses on start and streams the 28-byte ARP body.
// Build macro ARP_PAD_EN appends 18 zero bytes for a 46-byte minimum payload.
module arp_data_tx
  import arp_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        arp_oper,
  input  logic [47:0] mac_s_addr,
  input  logic [31:0] ip_s_addr,
  input  logic [47:0] mac_d_addr,
  input  logic [31:0] ip_d_addr,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        data_last,
  output logic        busy,
  output logic        done
);

`ifdef ARP_PAD_EN
  localparam logic [5:0] LAST_IDX = 6'(ARP_PAD_LEN - 1);
`else
  localparam logic [5:0] LAST_IDX = 6'(ARP_LEN - 1);
`endif

  arp_tx_state_e state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          oper_q, oper_d;
  logic [47:0]   sha_q, sha_d;
  logic [31:0]   spa_q, spa_d;
  logic [47:0]   tha_q, tha_d;
  logic [31:0]   tpa_q, tpa_d;
  logic [7:0]    dataOut_q, dataOut_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [5:0]    cntNext;
  logic [63:0]   hdrWord;
  logic [7:0]    byteSel;

  // Next byte is always looked up for cnt_q+1 so the output register is ready one cycle ahead.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    oper_d    = oper_q;
    sha_d     = sha_q;
    spa_d     = spa_q;
    tha_d     = tha_q;
    tpa_d     = tpa_q;
    dataOut_d = dataOut_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    cntNext = cnt_q + 6'd1;
    hdrWord = {HTYPE, PTYPE, HLEN, PLEN, (oper_q ? OPER_RESP : OPER_RQ)};

    byteSel = 8'h00;
    if (cntNext < 6'd8)
      byteSel = 8'(hdrWord >> {3'd7 - cntNext[2:0], 3'b000});
    else if (cntNext < 6'd14)
      byteSel = 8'(sha_q >> {6'd13 - cntNext, 3'b000});
    else if (cntNext < 6'd18)
      byteSel = 8'(spa_q >> {6'd17 - cntNext, 3'b000});
    else if (cntNext < 6'd24)
      byteSel = 8'(tha_q >> {6'd23 - cntNext, 3'b000});
    else if (cntNext < 6'd28)
      byteSel = 8'(tpa_q >> {6'd27 - cntNext, 3'b000});

    case (state_q)
      ST_IDLE: begin
        cnt_d     = 6'd0;
        dataOut_d = 8'h00;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          oper_d    = arp_oper;
          sha_d     = mac_s_addr;
          spa_d     = ip_s_addr;
          // Requests never carry a target MAC, whatever the control logic drives.
          tha_d     = arp_oper ? mac_d_addr : MAC_Z;
          tpa_d     = ip_d_addr;
          state_d   = ST_HDR;
          dataOut_d = HTYPE[15:8];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
      end

      default: begin
        if (valid_q && data_ready) begin
          cnt_d = cntNext;
          if (cnt_q == LAST_IDX) begin
            state_d   = ST_DONE;
            dataOut_d = 8'h00;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d   = txStateOf(cntNext);
            dataOut_d = byteSel;
            last_d    = (cntNext == LAST_IDX);
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      oper_q    <= 1'b0;
      sha_q     <= 48'h0;
      spa_q     <= 32'h0;
      tha_q     <= 48'h0;
      tpa_q     <= 32'h0;
      dataOut_q <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      oper_q    <= oper_d;
      sha_q     <= sha_d;
      spa_q     <= spa_d;
      tha_q     <= tha_d;
      tpa_q     <= tpa_d;
      dataOut_q <= dataOut_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign data_out   = dataOut_q;
  assign data_valid = valid_q;
  assign data_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_arp_data_tx.sv
// Scoreboard bench for arp_data_tx; honours ARP_PAD_EN for the 46-byte frame length.
module tb_arp_data_tx;

`ifdef ARP_PAD_EN
  localparam int FRAME_LEN = 46;
`else
  localparam int FRAME_LEN = 28;
`endif

  typedef struct {
    logic [7:0] b;
    logic       last;
  } expByte_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic        arp_oper;
  logic [47:0] mac_s_addr;
  logic [31:0] ip_s_addr;
  logic [47:0] mac_d_addr;
  logic [31:0] ip_d_addr;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        data_last;
  logic        busy;
  logic        done;

  expByte_t expQ[$];
  int       total = 0;
  int       bad = 0;
  int       xferCnt = 0;
  logic     busyExp = 1'b0;
  logic     doneDue = 1'b0;

  arp_data_tx dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .arp_oper   (arp_oper),
    .mac_s_addr (mac_s_addr),
    .ip_s_addr  (ip_s_addr),
    .mac_d_addr (mac_d_addr),
    .ip_d_addr  (ip_d_addr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream built straight from the ARP field layout.
  task automatic pushFrame(input logic oper, input logic [47:0] sha, input logic [31:0] spa,
                           input logic [47:0] tha, input logic [31:0] tpa);
    logic [7:0]  bytes[$];
    logic [63:0] hdr;
    logic [47:0] thaEff;
    hdr    = {16'h0001, 16'h0800, 8'h06, 8'h04, (oper ? 16'h0002 : 16'h0001)};
    thaEff = oper ? tha : 48'h0;
    for (int i = 0; i < 8; i++) bytes.push_back(hdr[63-8*i -: 8]);
    for (int i = 0; i < 6; i++) bytes.push_back(sha[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) bytes.push_back(spa[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) bytes.push_back(thaEff[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) bytes.push_back(tpa[31-8*i -: 8]);
    while (bytes.size() < FRAME_LEN) bytes.push_back(8'h00);
    for (int k = 0; k < FRAME_LEN; k++) expQ.push_back('{bytes[k], (k == FRAME_LEN - 1)});
  endtask

  // Issues start for one cycle, then scrambles the inputs to prove they were latched.
  task automatic applyStimulus(input logic oper, input logic [47:0] sha, input logic [31:0] spa,
                               input logic [47:0] tha, input logic [31:0] tpa);
    @(posedge aclk); #1;
    arp_oper   = oper;
    mac_s_addr = sha;
    ip_s_addr  = spa;
    mac_d_addr = tha;
    ip_d_addr  = tpa;
    start      = 1'b1;
    @(posedge aclk); #1;
    start   = 1'b0;
    xferCnt = 0;
    pushFrame(oper, sha, spa, tha, tpa);
    busyExp    = 1'b1;
    arp_oper   = ~oper;
    mac_s_addr = {16'($urandom), $urandom};
    ip_s_addr  = $urandom;
    mac_d_addr = {16'($urandom), $urandom};
    ip_d_addr  = $urandom;
  endtask

  task automatic waitXfer(input int n);
    int cyc = 0;
    while (xferCnt < n && cyc < 300) begin
      @(posedge aclk); #1;
      cyc++;
    end
    if (xferCnt < n) checkOutput("wait_xfer_timeout", 64'(xferCnt), 64'(n));
  endtask

  task automatic waitDone();
    int cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge aclk); #1;
      cyc++;
    end
    checkOutput("wait_done", done, 1'b1);
  endtask

  initial begin
    aresetn    = 1'b0;
    start      = 1'b0;
    arp_oper   = 1'b0;
    mac_s_addr = 48'h0;
    ip_s_addr  = 32'h0;
    mac_d_addr = 48'h0;
    ip_d_addr  = 32'h0;
    data_ready = 1'b1;

    fork
      begin : monitor
        logic wasLast;
        forever begin
          @(negedge aclk);
          if (aresetn) begin
            if (doneDue) busyExp = 1'b0;
            checkOutput("busy", busy, busyExp);
            checkOutput("done", done, doneDue);
            doneDue = 1'b0;
            checkOutput("valid", data_valid, expQ.size() > 0);
            if (data_valid && expQ.size() > 0) begin
              checkOutput($sformatf("byte%0d", xferCnt), data_out, expQ[0].b);
              checkOutput($sformatf("last%0d", xferCnt), data_last, expQ[0].last);
              if (data_ready) begin
                wasLast = expQ[0].last;
                void'(expQ.pop_front());
                xferCnt++;
                if (wasLast) doneDue = 1'b1;
              end
            end
          end
        end
      end

      begin : mainSeq
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_valid", data_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_last", data_last, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_data", data_out, 8'h00);
        aresetn = 1'b1;

        $display("[TB] reply frame, ready held high");
        applyStimulus(1'b1, 48'h020000000001, 32'hC0A8010A, 48'h020000000099, 32'hC0A80114);
        waitDone();

        $display("[TB] request frame started the cycle after done");
        applyStimulus(1'b0, 48'h0A1B2C3D4E5F, 32'h0A000001, 48'hFFFFFFFFFFFF, 32'h0A0000FE);
        waitDone();

        $display("[TB] backpressure at byte 10");
        applyStimulus(1'b1, 48'h020000000001, 32'hC0A8010A, 48'h020000000099, 32'hC0A80114);
        waitXfer(10);
        data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge aclk);
          checkOutput("stall_data", data_out, 8'h00);
          checkOutput("stall_valid", data_valid, 1'b1);
          @(posedge aclk); #1;
        end
        data_ready = 1'b1;
        waitDone();

        $display("[TB] start while busy and start coincident with done");
        repeat (2) @(posedge aclk);
        applyStimulus(1'b1, 48'h112233445566, 32'h01020304, 48'h778899AABBCC, 32'h05060708);
        waitXfer(5);
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        waitDone();
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_valid", data_valid, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 48'h020000000001, 32'hC0A8010A, 48'h020000000099, 32'hC0A80114);
        waitXfer(15);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_valid", data_valid, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_last", data_last, 1'b0);
        checkOutput("mid_rst_data", data_out, 8'h00);
        expQ.delete();
        busyExp = 1'b0;
        doneDue = 1'b0;
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        applyStimulus(1'b0, 48'h02AABBCCDDEE, 32'hAC100001, 48'h123456789ABC, 32'hAC100002);
        waitDone();
        repeat (4) @(posedge aclk);
        #1;
        checkOutput("end_queue_empty", 64'(expQ.size()), 64'd0);
      end
    join_any

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
